// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and small helpers used by the initiator and lane steering logic.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Sizes above word are not supported on a 32-bit bus and collapse to word.
  function automatic hsize_e norm_size(input logic [2:0] size);
    if (size > 3'd2) begin
      return HSIZE_WORD;
    end
    return hsize_e'(size);
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input hsize_e size);
    case (size)
      HSIZE_HALF: return {addr[31:1], 1'b0};
      HSIZE_WORD: return {addr[31:2], 2'b00};
      default:    return addr;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte-lane steering: replicates write data across lanes and extracts/zero-extends read data.
module ahb_lane_steer
  import ahb_lite_pkg::*;
(
  input  hsize_e      i_wsize,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_wdata,
  input  hsize_e      i_rsize,
  input  logic [1:0]  i_raddr,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  always_comb begin
    o_wdata = i_wdata;
    case (i_wsize)
      HSIZE_BYTE: o_wdata = {4{i_wdata[7:0]}};
      HSIZE_HALF: o_wdata = {2{i_wdata[15:0]}};
      default:    o_wdata = i_wdata;
    endcase
  end

  // Little-endian lanes: addr[1:0] picks the byte, addr[1] picks the half.
  always_comb begin
    o_rdata = i_rdata;
    case (i_rsize)
      HSIZE_BYTE: o_rdata = {24'b0, i_rdata[{i_raddr, 3'b000} +: 8]};
      HSIZE_HALF: o_rdata = i_raddr[1] ? {16'b0, i_rdata[31:16]} : {16'b0, i_rdata[15:0]};
      default:    o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready command stream to single transfers over an
// address/data pipeline, with wait-state, two-cycle error and in-order responses.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = HPROT_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  logic        r_a_v;
  logic [31:0] r_a_addr;
  hsize_e      r_a_size;
  logic        r_a_write;
  logic [31:0] r_a_wdata;

  logic        r_d_v;
  logic        r_d_write;
  hsize_e      r_d_size;
  logic [1:0]  r_d_lane;

  logic        r_cancel;
  logic [31:0] r_hwdata;
  logic        r_rsp_v;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_nonseq;
  logic        w_err_first;
  logic        w_accept;
  logic        w_complete;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;

  assign w_nonseq    = r_a_v & ~r_cancel;
  assign w_err_first = r_d_v & ~HREADY & (HRESP == HRESP_ERROR);
  assign cmd_ready   = (HREADY | ~r_a_v) & ~r_cancel & ~w_err_first;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_complete  = r_d_v & HREADY;

  ahb_lane_steer u_lane_steer (
    .i_wsize (r_a_size),
    .i_wdata (r_a_wdata),
    .o_wdata (w_wdata_rep),
    .i_rsize (r_d_size),
    .i_raddr (r_d_lane),
    .i_rdata (HRDATA),
    .o_rdata (w_rdata_ext)
  );

  // An empty A-stage may fill during a wait state; a full one only moves on HREADY.
  // While cancelling, cmd_ready is low so the retained command simply holds.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_a_v     <= 1'b0;
      r_a_addr  <= '0;
      r_a_size  <= HSIZE_BYTE;
      r_a_write <= 1'b0;
      r_a_wdata <= '0;
    end else if (w_accept) begin
      r_a_v     <= 1'b1;
      r_a_addr  <= cmd_addr;
      r_a_size  <= norm_size(cmd_size);
      r_a_write <= cmd_write;
      r_a_wdata <= cmd_wdata;
    end else if (HREADY && !r_cancel) begin
      r_a_v <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cancel <= 1'b0;
    end else if (w_err_first) begin
      r_cancel <= 1'b1;
    end else if (HREADY) begin
      r_cancel <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_d_v     <= 1'b0;
      r_d_write <= 1'b0;
      r_d_size  <= HSIZE_BYTE;
      r_d_lane  <= 2'b00;
      r_hwdata  <= '0;
    end else if (HREADY) begin
      r_d_v     <= w_nonseq;
      r_d_write <= r_a_write;
      r_d_size  <= r_a_size;
      r_d_lane  <= r_a_addr[1:0];
      r_hwdata  <= w_wdata_rep;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rsp_v     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_v <= w_complete;
      if (w_complete) begin
        r_rsp_err   <= (HRESP == HRESP_ERROR);
        r_rsp_rdata <= r_d_write ? 32'h0 : w_rdata_ext;
      end
    end
  end

  assign HADDR     = align_addr(r_a_addr, r_a_size);
  assign HTRANS    = w_nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE    = r_a_write;
  assign HSIZE     = r_a_size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HWDATA    = r_hwdata;
  assign rsp_valid = r_rsp_v;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a transaction-level bus model checked every cycle.
module tb_ahb_lite_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  s;
    logic [31:0] d;
  } cmd_t;

  cmd_t src_q[$];
  logic src_acc = 1'b0;

  ahb_lite_master #(
    .HPROT_VAL (4'b0011)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_nsize(input logic [2:0] s);
    return (s > 3'd2) ? 3'd2 : s;
  endfunction

  function automatic logic [31:0] m_align(input logic [31:0] a, input logic [2:0] s);
    if (m_nsize(s) == 3'd2) return a & ~32'h3;
    if (m_nsize(s) == 3'd1) return a & ~32'h1;
    return a;
  endfunction

  function automatic logic [31:0] m_rep(input logic [31:0] d, input logic [2:0] s);
    if (m_nsize(s) == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (m_nsize(s) == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] rd, input logic [31:0] a,
                                        input logic [2:0] s);
    if (m_nsize(s) == 3'd0) return (rd >> (8 * (a % 4))) & 32'hFF;
    if (m_nsize(s) == 3'd1) return (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    return rd;
  endfunction

  // Transaction model: pend_q = accepted but address phase not yet taken,
  // dph = transfer in its data phase, ev/erd/eerr = response due after the next edge.
  initial begin : model
    cmd_t        pend_q[$];
    cmd_t        dph;
    cmd_t        nc;
    bit          dph_v;
    bit          m_cancel;
    bit          ev;
    bit          eerr;
    bit          exp_ready;
    bit          exp_ns;
    bit          acc;
    logic [31:0] erd;
    dph_v = 0; m_cancel = 0; ev = 0; eerr = 0; erd = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        pend_q.delete();
        dph_v = 0; m_cancel = 0; ev = 0;
        check("rst_htrans", 32'(HTRANS), 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwrite", 32'(HWRITE), 32'd0);
        check("rst_hsize", 32'(HSIZE), 32'd0);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
      end else begin
        exp_ready = (HREADY || pend_q.size() == 0) && !m_cancel && !(dph_v && !HREADY && HRESP);
        exp_ns    = (pend_q.size() != 0) && !m_cancel;
        check("m_cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        check("m_htrans", 32'(HTRANS), exp_ns ? 32'd2 : 32'd0);
        check("m_hburst", 32'(HBURST), 32'd0);
        check("m_hprot", 32'(HPROT), 32'h3);
        if (exp_ns) begin
          check("m_haddr", HADDR, m_align(pend_q[0].a, pend_q[0].s));
          check("m_hsize", 32'(HSIZE), 32'(m_nsize(pend_q[0].s)));
          check("m_hwrite", 32'(HWRITE), 32'(pend_q[0].w));
        end
        if (dph_v && dph.w) check("m_hwdata", HWDATA, m_rep(dph.d, dph.s));
        check("m_rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
          check("m_rsp_rdata", rsp_rdata, erd);
          check("m_rsp_err", 32'(rsp_err), 32'(eerr));
        end
        // Predict the coming edge.
        acc = cmd_valid && exp_ready;
        nc.w = cmd_write; nc.a = cmd_addr; nc.s = cmd_size; nc.d = cmd_wdata;
        if (HREADY) begin
          ev = dph_v;
          if (dph_v) begin
            erd  = dph.w ? 32'd0 : m_ext(HRDATA, dph.a, dph.s);
            eerr = HRESP;
          end
          if (m_cancel) begin
            m_cancel = 0;
            dph_v    = 0;
          end else if (pend_q.size() != 0) begin
            dph   = pend_q.pop_front();
            dph_v = 1;
          end else begin
            dph_v = 0;
          end
        end else begin
          ev = 0;
          if (dph_v && HRESP) m_cancel = 1;
        end
        if (acc) pend_q.push_back(nc);
      end
    end
  end

  initial begin : acc_sampler
    forever begin
      @(negedge HCLK);
      src_acc = HRESETn && cmd_valid && cmd_ready;
    end
  end

  task automatic drive_src();
    if (src_q.size() != 0) begin
      cmd_valid = 1'b1;
      cmd_write = src_q[0].w;
      cmd_addr  = src_q[0].a;
      cmd_size  = src_q[0].s;
      cmd_wdata = src_q[0].d;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] d);
    cmd_t c;
    c.w = w; c.a = a; c.s = s; c.d = d;
    src_q.push_back(c);
    drive_src();
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
    if (src_acc && src_q.size() != 0) void'(src_q.pop_front());
    drive_src();
  endtask

  task automatic at_neg();
    @(negedge HCLK);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("init_htrans", 32'(HTRANS), 32'd0);
    check("init_rsp_valid", 32'(rsp_valid), 32'd0);
    HRESETn = 1'b1;
    nxt();

    // Word write, zero wait.
    push(1'b1, 32'h2000_0010, 3'd2, 32'hDEAD_BEEF);
    nxt(); at_neg();
    check("wr_htrans", 32'(HTRANS), 32'd2);
    check("wr_haddr", HADDR, 32'h2000_0010);
    check("wr_hsize", 32'(HSIZE), 32'd2);
    check("wr_hwrite", 32'(HWRITE), 32'd1);
    nxt(); at_neg();
    check("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    check("wr_idle", 32'(HTRANS), 32'd0);
    nxt(); at_neg();
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_err", 32'(rsp_err), 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    nxt(); at_neg();
    check("wr_rsp_pulse", 32'(rsp_valid), 32'd0);
    nxt();

    // Byte and half reads with lane extraction.
    HRDATA = 32'hA1B2_C3D4;
    push(1'b0, 32'h0000_0403, 3'd0, 32'h0);
    push(1'b0, 32'h0000_0402, 3'd1, 32'h0);
    nxt(); at_neg();
    check("rb_haddr", HADDR, 32'h0000_0403);
    check("rb_hsize", 32'(HSIZE), 32'd0);
    nxt(); at_neg();
    check("rh_haddr", HADDR, 32'h0000_0402);
    check("rh_hsize", 32'(HSIZE), 32'd1);
    nxt(); at_neg();
    check("rb_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rb_rsp_rdata", rsp_rdata, 32'h0000_00A1);
    nxt(); at_neg();
    check("rh_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rh_rsp_rdata", rsp_rdata, 32'h0000_A1B2);
    nxt(); nxt();

    // Four back-to-back writes; the third uses an oversize code.
    for (int k = 0; k < 4; k++) begin
      push(1'b1, 32'h100 + 32'(4 * k), (k == 2) ? 3'd3 : 3'd2, 32'hA0 + 32'(k));
    end
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check("b2b_ready", 32'(cmd_ready), 32'd1);
      if (k > 0) check("b2b_haddr", HADDR, 32'h100 + 32'(4 * (k - 1)));
      nxt();
    end
    at_neg();
    check("b2b_haddr_last", HADDR, 32'h10C);
    check("b2b_rsp1", 32'(rsp_valid), 32'd1);
    nxt(); at_neg();
    check("b2b_rsp2", 32'(rsp_valid), 32'd1);
    nxt(); at_neg();
    check("b2b_rsp3", 32'(rsp_valid), 32'd1);
    nxt(); at_neg();
    check("b2b_rsp_end", 32'(rsp_valid), 32'd0);
    nxt();

    // Two wait states on a write data phase with a read queued behind it.
    HRDATA = 32'h5566_7788;
    push(1'b1, 32'h200, 3'd2, 32'h1122_3344);
    push(1'b0, 32'h204, 3'd2, 32'h0);
    nxt(); at_neg();
    check("ws_haddr0", HADDR, 32'h200);
    nxt(); HREADY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      check("ws_haddr_hold", HADDR, 32'h204);
      check("ws_htrans_hold", 32'(HTRANS), 32'd2);
      check("ws_hwdata_hold", HWDATA, 32'h1122_3344);
      check("ws_ready_low", 32'(cmd_ready), 32'd0);
      check("ws_no_rsp", 32'(rsp_valid), 32'd0);
      nxt();
    end
    HREADY = 1'b1;
    at_neg();
    check("ws_ready_back", 32'(cmd_ready), 32'd1);
    nxt(); at_neg();
    check("ws_wr_rsp", 32'(rsp_valid), 32'd1);
    check("ws_wr_rdata", rsp_rdata, 32'd0);
    nxt(); at_neg();
    check("ws_rd_rsp", 32'(rsp_valid), 32'd1);
    check("ws_rd_rdata", rsp_rdata, 32'h5566_7788);
    nxt(); nxt();

    // Two-cycle error on a read with a write queued; the write re-issues.
    HRDATA = 32'h0;
    push(1'b0, 32'hE000_0000, 3'd2, 32'h0);
    push(1'b1, 32'h300, 3'd2, 32'hCAFE_F00D);
    nxt(); at_neg();
    check("er_haddr", HADDR, 32'hE000_0000);
    nxt(); HREADY = 1'b0; HRESP = 1'b1;
    at_neg();
    check("er1_ready", 32'(cmd_ready), 32'd0);
    check("er1_haddr", HADDR, 32'h300);
    nxt(); HREADY = 1'b1; HRESP = 1'b1;
    at_neg();
    check("er2_idle", 32'(HTRANS), 32'd0);
    check("er2_ready", 32'(cmd_ready), 32'd0);
    nxt(); HRESP = 1'b0;
    at_neg();
    check("er_rsp_valid", 32'(rsp_valid), 32'd1);
    check("er_rsp_err", 32'(rsp_err), 32'd1);
    check("er_reissue", 32'(HTRANS), 32'd2);
    check("er_reissue_addr", HADDR, 32'h300);
    nxt(); at_neg();
    check("er_wr_hwdata", HWDATA, 32'hCAFE_F00D);
    nxt(); at_neg();
    check("er_wr_rsp", 32'(rsp_valid), 32'd1);
    check("er_wr_err", 32'(rsp_err), 32'd0);
    nxt(); nxt();

    // Reset during a wait-stated data phase.
    HRDATA = 32'h1234_5678;
    push(1'b0, 32'h40, 3'd2, 32'h0);
    nxt(); at_neg();
    check("rs_htrans", 32'(HTRANS), 32'd2);
    nxt(); HREADY = 1'b0;
    #2 HRESETn = 1'b0;
    #1;
    check("rs_async_htrans", 32'(HTRANS), 32'd0);
    check("rs_async_haddr", HADDR, 32'd0);
    check("rs_async_rsp", 32'(rsp_valid), 32'd0);
    nxt(); nxt();
    HRESETn = 1'b1; HREADY = 1'b1;
    nxt(); at_neg();
    check("rs_no_rsp", 32'(rsp_valid), 32'd0);
    nxt();
    push(1'b1, 32'h44, 3'd0, 32'h5A);
    nxt(); at_neg();
    check("rs_new_htrans", 32'(HTRANS), 32'd2);
    check("rs_new_haddr", HADDR, 32'h44);
    nxt(); at_neg();
    check("rs_new_hwdata", HWDATA, 32'h5A5A_5A5A);
    nxt(); at_neg();
    check("rs_new_rsp", 32'(rsp_valid), 32'd1);
    nxt(); nxt();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
AHB-Lite initiator that turns a simple valid/ready command stream into single AHB-Lite transfers. It drives the system bus towards AHB-Lite slaves such as the on-chip memory and peripherals. The block runs a two-stage address/data pipeline, so back-to-back commands issue one transfer per cycle with zero wait states. It honours HREADY wait states and the two-cycle HRESP error response, and returns in-order responses with lane-extracted read data.

Parameters:
HPROT_VAL, 4'b0011, constant value driven on HPROT (non-cacheable, non-bufferable, privileged data access).

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted this cycle when cmd_valid=1
cmd_write  in  1  1=write, 0=read
cmd_addr  in  32  byte address
cmd_size  in  3  0=byte, 1=half, 2=word; values above 2 are treated as word
cmd_wdata  in  32  write data, LSB-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle pulse: oldest outstanding transfer completed
rsp_rdata  out  32  read data, zero-extended and lane-extracted; 0 for writes
rsp_err  out  1  transfer ended with HRESP=ERROR
HADDR  out  32  address-phase address
HTRANS  out  2  IDLE=00 or NONSEQ=10 only
HWRITE  out  1  direction
HSIZE  out  3  000/001/010
HBURST  out  3  fixed 000 (SINGLE)
HPROT  out  4  fixed HPROT_VAL
HWDATA  out  32  data-phase write data
HRDATA  in  32  read data
HREADY  in  1  transfer-done / bus-ready
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values (async on HRESETn low): HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. All pipeline valid flags are cleared and any in-flight transfer is discarded with no response.
- Pipeline registers: A-stage (aphase_v, addr, size, write, wdata) and D-stage (dphase_v, write, size, addr[1:0]). A cancel flag also exists.
- AHB outputs are driven from the A-stage. HTRANS=NONSEQ when aphase_v=1 and cancel=0, otherwise IDLE.
- HADDR is aligned down to the transfer size: half clears bit 0, word clears bits 1:0.
- cmd_ready = HREADY | ~aphase_v, gated off while cancel=1 or while an error's first cycle is observed. This is combinational, with no dependency on cmd_valid.
- On a rising edge with HREADY=1:
  - D-stage <= A-stage contents if NONSEQ was driven; otherwise D-stage is emptied.
  - HWDATA <= A-stage wdata, replicated per size: byte x4, half x2, word as-is.
  - A-stage <= accepted command, or aphase_v=0 if no command is accepted.
- HREADY=0: A-stage, D-stage, HADDR/HTRANS/HSIZE/HWRITE and HWDATA all hold stable.
- Completion: an edge with dphase_v=1 and HREADY=1 registers rsp_valid=1 for one cycle.
  - rsp_err=HRESP.
  - rsp_rdata is set for reads only: the byte/half is selected from HRDATA by D-stage addr[1:0] and zero-extended; a word passes through.
  - Writes return rsp_rdata=0.
- Latency: command accepted at edge T0, NONSEQ during T0..T1, data phase T1..T2, rsp_valid high during the cycle after T2. That is 3 cycles at zero wait states, with throughput of 1 command per cycle.
- Error handling:
  - A cycle with dphase_v=1, HREADY=0, HRESP=1 sets cancel=1. HTRANS is forced to IDLE on the next cycle; the A-stage command is retained, not dropped.
  - On the closing edge (HREADY=1, HRESP=1): the error response is issued, the D-stage is emptied, and the A-stage does not advance. Cancel then clears and the retained command re-issues as NONSEQ next cycle.
- Responses are strictly in command order. At most 2 transfers are outstanding.
- No response backpressure: the consumer must accept rsp_valid every cycle.
- Simultaneous events: acceptance and completion on the same edge are both legal and independent. cmd_valid is ignored while cmd_ready=0, and the command must be held stable by the source.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE codes (BYTE, HALF, WORD).
  - HBURST_SINGLE.
  - HRESP_OKAY/HRESP_ERROR.
  - Default HPROT constant.
- One combinational sub-module, ahb_lane_steer, performs write-data replication and read-data extraction/zero-extension from size and addr[1:0]. It can be shared with future AHB slaves.

Test Plan:
- Word write 0x20000010 / 0xDEADBEEF, HREADY=1 throughout -> one NONSEQ cycle with HADDR=0x20000010, HSIZE=010, HWRITE=1; next cycle HWDATA=0xDEADBEEF; then rsp_valid pulse, rsp_err=0, rsp_rdata=0.
- Byte read at 0x00000403 with slave HRDATA=0xA1B2C3D4 -> HADDR=0x00000403, HSIZE=000; rsp_rdata=0x000000A1. Half read at 0x00000402 -> rsp_rdata=0x0000A1B2.
- Four back-to-back writes with cmd_valid held and zero wait -> four consecutive NONSEQ cycles at increasing addresses, cmd_ready=1 throughout, four consecutive rsp_valid pulses in order.
- Write data phase with HREADY low for 2 cycles while the next read is in the A-stage -> HADDR/HTRANS/HWDATA stable, cmd_ready=0 for 2 cycles, responses delayed by exactly 2 cycles.
- Read to 0xE0000000 answers (HREADY=0, HRESP=1) then (HREADY=1, HRESP=1) with a pending write queued -> HTRANS=IDLE in the second error cycle, rsp_err=1 for the read, the write re-issues as NONSEQ next cycle and completes with rsp_err=0.
- HRESETn asserted during a wait-stated data phase -> outputs at reset values immediately, no rsp_valid; a new command after release issues normally.
